hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
//  Owns the architectural HI/LO register pair and the multi-cycle MULT/MULTU/DIV/DIVU engine.
//  Sits directly downstream of the HI/LO write decode:
//   - commits its per-field write enables/data (MTHI/MTLO);
//   - executes multiply/divide requests issued from execute;
//   - drives a busy stall back to the pipeline.
//  hi/lo outputs feed MFHI/MFLO forwarding.
// PARAMETERS
//  DIV_ITERS  32  radix-2 divider iterations; must equal the operand width (32)
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   synchronous reset, active-high
//  req_valid   in   1   mul/div request; accepted only when busy=0
//  req_op      in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  req_a       in   32  rs operand (multiplicand / dividend)
//  req_b       in   32  rt operand (multiplier / divisor)
//  flush       in   1   abort any in-flight op (exception/kill)
//  wr_hi_en    in   1   direct HI write (MTHI commit)
//  wr_hi_data  in   32  data for HI
//  wr_lo_en    in   1   direct LO write (MTLO commit)
//  wr_lo_data  in   32  data for LO
//  busy        out  1   op in flight; pipeline must stall mul/div/MFHI/MFLO
//  done        out  1   one-cycle pulse: hi/lo now hold the op result
//  hi          out  32  architectural HI
//  lo          out  32  architectural LO
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE; hi=lo=0; busy=0; done=0; all internal regs cleared.
//  FSM states: IDLE, MUL, DIV, FIX; busy = (state != IDLE), combinational.
//  Accept: in IDLE with req_valid=1 and flush=0 at cycle T.
//   - Operands and op are latched.
//   - MULT/MULTU go to MUL; DIV/DIVU go to DIV with the iteration counter cleared.
//   - req_valid while busy=1 is ignored; upstream must hold it.
//  MUL at cycle T+1:
//   - 64-bit product: signed for MULT, unsigned for MULTU.
//   - {hi,lo} <= product at the end of T+1; next state is IDLE.
//   - New values visible at T+2; done=1 at T+2.
//  DIV at cycles T+1 .. T+DIV_ITERS:
//   - Restoring division on the magnitudes (|a|,|b| for DIV; raw operands for DIVU).
//   - One quotient bit per cycle, MSB first; 33-bit partial remainder.
//   - Next state is FIX after iteration DIV_ITERS-1.
//  FIX at cycle T+33, sign correction:
//   - quotient negated if sign(a)^sign(b) (DIV only);
//   - remainder takes the sign of a (DIV only).
//   - lo <= quotient, hi <= remainder; next state is IDLE.
//   - New values visible at T+34; done=1 at T+34.
//  Divide by zero (b=0):
//   - Runs the full latency.
//   - Result fixed at lo=32'hFFFF_FFFF, hi=a; no sign correction applied.
//  Overflow, DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0 (natural 32-bit wrap).
//  Direct writes:
//   - wr_hi_en/wr_lo_en update hi/lo at the clock edge in any state.
//   - Fields are independent.
//  Simultaneous direct write and op commit in the same cycle: op commit wins for both hi and lo.
//  Flush:
//   - Returns the FSM to IDLE next cycle; hi/lo unchanged by the aborted op; done stays 0.
//   - flush beats req_valid in the same cycle (request not accepted).
//   - flush beats commit in the MUL/FIX cycle (no commit).
//   - Direct writes in a flush cycle still apply.
//  done:
//   - Registered; exactly 1 cycle per committed op; never asserted for direct writes or aborted ops.
//  Back-to-back ops: a new request may be accepted in the cycle done=1 (state is IDLE).
// TESTING
//  1. Reset with all inputs 0 -> hi=lo=0, busy=0, done=0 in the cycle after reset deasserts.
//  2. MULT, a=0xFFFF_FFFE (-2), b=3 at T:
//     -> busy=1 at T+1; hi=0xFFFF_FFFF, lo=0xFFFF_FFFA and done=1 at T+2.
//     MULTU with the same operands -> hi=0x0000_0002, lo=0xFFFF_FFFA.
//  3. DIV, a=-7 (0xFFFF_FFF9), b=2:
//     -> busy=1 for T+1..T+33; at T+34 lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1), done=1.
//     DIVU, a=100, b=7 -> lo=14, hi=2.
//  4. DIVU, a=0x1234_5678, b=0 -> at T+34 lo=0xFFFF_FFFF, hi=0x1234_5678.
//     DIV 0x8000_0000 / -1 -> lo=0x8000_0000, hi=0.
//  5. DIV in flight with flush at T+10:
//     -> busy=0 at T+11, hi/lo keep the prior values, no done pulse.
//     req_valid+flush in the same cycle -> not accepted.
//  6. wr_hi_en (data 0xAAAA_AAAA) at T+1 of a MULT that commits at T+1 -> the product wins.
//     wr_lo_en=1 (0x55) while idle -> lo=0x55 next cycle, hi unchanged.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// HI/LO architectural register pair with a multi-cycle MULT/MULTU/DIV/DIVU engine.
// A single-cycle multiply, a radix-2 restoring divider and MTHI/MTLO direct writes.
module hilo_muldiv_unit #(
    parameter int DIV_ITERS = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    input  logic [1:0]  i_req_op,
    input  logic [31:0] i_req_a,
    input  logic [31:0] i_req_b,
    input  logic        i_flush,
    input  logic        i_wr_hi_en,
    input  logic [31:0] i_wr_hi_data,
    input  logic        i_wr_lo_en,
    input  logic [31:0] i_wr_lo_data,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam int              CNT_W     = $clog2(DIV_ITERS);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERS - 1);

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        cond_neg = neg ? (~v + 32'd1) : v;
    endfunction

    logic [1:0]       r_state;
    logic             r_op_signed;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_dvd;
    logic [31:0]      r_dvs;
    logic [32:0]      r_rem;
    logic [31:0]      r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             r_done;

    logic        w_accept;
    logic        w_req_signed;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [1:0]  w_state_nxt;
    logic        w_commit;
    logic [32:0] w_shift_rem;
    logic [33:0] w_diff;
    logic        w_fits;
    logic [63:0] w_a64;
    logic [63:0] w_b64;
    logic [63:0] w_prod;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;
    logic [31:0] w_commit_hi;
    logic [31:0] w_commit_lo;

    assign w_accept     = (r_state == S_IDLE) && i_req_valid && !i_flush;
    assign w_req_signed = ~i_req_op[0];
    assign w_a_mag      = cond_neg(i_req_a, w_req_signed & i_req_a[31]);
    assign w_b_mag      = cond_neg(i_req_b, w_req_signed & i_req_b[31]);
    assign w_commit     = ((r_state == S_MUL) || (r_state == S_FIX)) && !i_flush;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    assign w_shift_rem = {r_rem[31:0], r_dvd[31]};
    assign w_diff      = {1'b0, w_shift_rem} - {2'b00, r_dvs};
    assign w_fits      = ~w_diff[33];

    // Sign-extend only for MULT so one 64x64 truncated product serves both ops.
    assign w_a64  = {{32{r_op_signed & r_a[31]}}, r_a};
    assign w_b64  = {{32{r_op_signed & r_b[31]}}, r_b};
    assign w_prod = w_a64 * w_b64;

    // Divide by zero bypasses sign correction and reports a fixed pattern.
    assign w_fix_lo = (r_b == 32'd0) ? 32'hFFFF_FFFF : cond_neg(r_quo, r_neg_q);
    assign w_fix_hi = (r_b == 32'd0) ? r_a : cond_neg(r_rem[31:0], r_neg_r);

    assign w_commit_hi = (r_state == S_MUL) ? w_prod[63:32] : w_fix_hi;
    assign w_commit_lo = (r_state == S_MUL) ? w_prod[31:0]  : w_fix_lo;

    // Next-state selection; flush always returns to idle.
    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        w_state_nxt = i_req_op[1] ? S_DIV : S_MUL;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_MUL: w_state_nxt = S_IDLE;
                S_DIV: begin
                    if (r_cnt == LAST_ITER) begin
                        w_state_nxt = S_FIX;
                    end else begin
                        w_state_nxt = S_DIV;
                    end
                end
                S_FIX:   w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture and divider iteration datapath.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_op_signed <= 1'b0;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_dvd       <= 32'd0;
            r_dvs       <= 32'd0;
            r_rem       <= 33'd0;
            r_quo       <= 32'd0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
        end else if (w_accept) begin
            r_op_signed <= w_req_signed;
            r_a         <= i_req_a;
            r_b         <= i_req_b;
            r_dvd       <= w_a_mag;
            r_dvs       <= w_b_mag;
            r_rem       <= 33'd0;
            r_quo       <= 32'd0;
            r_cnt       <= '0;
            r_neg_q     <= w_req_signed & (i_req_a[31] ^ i_req_b[31]);
            r_neg_r     <= w_req_signed & i_req_a[31];
        end else if (r_state == S_DIV) begin
            r_dvd <= {r_dvd[30:0], 1'b0};
            r_rem <= w_fits ? w_diff[32:0] : w_shift_rem;
            r_quo <= {r_quo[30:0], w_fits};
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Architectural HI/LO: an op commit overrides same-cycle direct writes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                r_hi <= w_commit_hi;
                r_lo <= w_commit_lo;
            end else begin
                if (i_wr_hi_en) begin
                    r_hi <= i_wr_hi_data;
                end
                if (i_wr_lo_en) begin
                    r_lo <= i_wr_lo_data;
                end
            end
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: expected {hi,lo} results queued at issue, popped on done.
module tb_hilo_muldiv_unit;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_req_valid;
    logic [1:0]  i_req_op;
    logic [31:0] i_req_a;
    logic [31:0] i_req_b;
    logic        i_flush;
    logic        i_wr_hi_en;
    logic [31:0] i_wr_hi_data;
    logic        i_wr_lo_en;
    logic [31:0] i_wr_lo_data;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    hilo_muldiv_unit #(.DIV_ITERS(32)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_req_valid(i_req_valid), .i_req_op(i_req_op),
        .i_req_a(i_req_a), .i_req_b(i_req_b), .i_flush(i_flush),
        .i_wr_hi_en(i_wr_hi_en), .i_wr_hi_data(i_wr_hi_data),
        .i_wr_lo_en(i_wr_lo_en), .i_wr_lo_data(i_wr_lo_data),
        .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference results from native arithmetic: {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int     ia, ib;
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        ia = a; ib = b; sa = ia; sb = ib;
        ua = {32'd0, a}; ub = {32'd0, b};
        case (op)
            2'b00: model = sa * sb;
            2'b01: model = ua * ub;
            2'b10: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb; r = sa % sb;
                    model = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else model = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Issue one op from idle, then wait (bounded) for done and compare against the queue head.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        int n;
        logic [63:0] e;
        exp_q.push_back(exp);
        i_req_valid = 1'b1; i_req_op = op; i_req_a = a; i_req_b = b;
        tick();
        i_req_valid = 1'b0;
        check({tag, "_busy"}, 64'(o_busy), 64'd1);
        n = 1;
        while (!o_done && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        e = exp_q.pop_front();
        check(tag, {o_hi, o_lo}, e);
    endtask

    initial begin
        int done_cnt;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        i_reset = 1'b1; i_req_valid = 1'b0; i_req_op = 2'b00; i_req_a = 32'd0; i_req_b = 32'd0;
        i_flush = 1'b0; i_wr_hi_en = 1'b0; i_wr_hi_data = 32'd0; i_wr_lo_en = 1'b0; i_wr_lo_data = 32'd0;
        repeat (3) tick();
        i_reset = 1'b0;
        tick();
        check("reset_hilo", {o_hi, o_lo}, 64'd0);
        check("reset_busy_done", {62'd0, o_busy, o_done}, 64'd0);

        run_op("mult_neg",  2'b00, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 2);
        run_op("multu",     2'b01, 32'hFFFF_FFFE, 32'd3, {32'h0000_0002, 32'hFFFF_FFFA}, 2);
        run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
        run_op("divu",      2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 34);
        run_op("divu_zero", 2'b11, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, 34);
        run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 34);
        run_op("div_zero",  2'b10, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF}, 34);
        run_op("div_mix",   2'b10, 32'd17, 32'hFFFF_FFFB, {32'd2, 32'hFFFF_FFFD}, 34);
        run_op("divu_big",  2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, {32'd1, 32'd1}, 34);
        tick();
        check("done_pulse_1cyc", 64'(o_done), 64'd0);

        for (int k = 0; k < 6; k++) begin
            rop = 2'($urandom_range(3, 0));
            ra = $urandom;
            rb = $urandom;
            if (rb == 32'd0) rb = 32'd1;
            run_op($sformatf("rand%0d", k), rop, ra, rb, model(rop, ra, rb), rop[1] ? 34 : 2);
        end
        run_op("divu_base", 2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 34);

        // DIV flushed at T+10; a direct LO write in the flush cycle still lands.
        i_req_valid = 1'b1; i_req_op = 2'b10; i_req_a = 32'hFFFF_FFF9; i_req_b = 32'd2;
        tick();
        i_req_valid = 1'b0;
        repeat (9) tick();
        i_flush = 1'b1; i_wr_lo_en = 1'b1; i_wr_lo_data = 32'h77;
        tick();
        i_flush = 1'b0; i_wr_lo_en = 1'b0;
        check("flush_busy", 64'(o_busy), 64'd0);
        check("flush_hilo", {o_hi, o_lo}, {32'd2, 32'h77});
        // Request together with flush must not be accepted.
        i_req_valid = 1'b1; i_req_op = 2'b11; i_req_a = 32'd9; i_req_b = 32'd3; i_flush = 1'b1;
        tick();
        i_req_valid = 1'b0; i_flush = 1'b0;
        check("reqflush_busy", 64'(o_busy), 64'd0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (o_done) done_cnt++;
            tick();
        end
        check("flush_no_done", 64'(done_cnt), 64'd0);
        check("flush_hilo_kept", {o_hi, o_lo}, {32'd2, 32'h77});

        // MULT aborted by flush in its commit cycle.
        i_req_valid = 1'b1; i_req_op = 2'b00; i_req_a = 32'd6; i_req_b = 32'd6;
        tick();
        i_req_valid = 1'b0; i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("mul_flush_done", {62'd0, o_busy, o_done}, 64'd0);
        check("mul_flush_hilo", {o_hi, o_lo}, {32'd2, 32'h77});

        // Op commit wins over same-cycle direct writes.
        i_req_valid = 1'b1; i_req_op = 2'b00; i_req_a = 32'd5; i_req_b = 32'd7;
        tick();
        i_req_valid = 1'b0;
        i_wr_hi_en = 1'b1; i_wr_hi_data = 32'hAAAA_AAAA; i_wr_lo_en = 1'b1; i_wr_lo_data = 32'h1111;
        tick();
        i_wr_hi_en = 1'b0; i_wr_lo_en = 1'b0;
        check("commit_wins_done", 64'(o_done), 64'd1);
        check("commit_wins_hilo", {o_hi, o_lo}, {32'd0, 32'd35});

        // Independent direct LO write while idle.
        i_wr_lo_en = 1'b1; i_wr_lo_data = 32'h55;
        tick();
        i_wr_lo_en = 1'b0;
        check("mtlo_hilo", {o_hi, o_lo}, {32'd0, 32'h55});
        check("mtlo_no_done", 64'(o_done), 64'd0);
        i_wr_hi_en = 1'b1; i_wr_hi_data = 32'hDEAD_BEEF;
        tick();
        i_wr_hi_en = 1'b0;
        check("mthi_hilo", {o_hi, o_lo}, {32'hDEAD_BEEF, 32'h55});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
